// File: rtl/random_checker_if.sv
// Serial test-pattern link between the bit source and random_checker.
// The master drives serial bits; the slave returns words, lock and error status.
interface random_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             bit_in;
  logic             bit_valid;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             locked;
  logic             err_flag;
  logic [ERR_W-1:0] err_count;

  modport master (
    output bit_in, bit_valid,
    input  word_out, word_valid, locked, err_flag, err_count
  );

  modport slave (
    input  bit_in, bit_valid,
    output word_out, word_valid, locked, err_flag, err_count
  );
endinterface

// File: rtl/random_checker.sv
// Receive-side checker for the x^4+x^3+1 (period 15) PRBS: deserializes, self-syncs, tracks lock, counts errors.
// Define RANDOM_CHECKER_SAT_EN to make err_count saturate instead of wrapping.
module random_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  random_checker_if.slave bus
);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [3:0]       hist_q, hist_d;
  logic [2:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             wvld_q, wvld_d;
  logic             eflag_q, eflag_d;
  logic [ERR_W-1:0] ecnt_q, ecnt_d;
  logic [WIDTH-1:0] shift_w;
  logic             pred;

  assign shift_w = {shreg_q, bus.bit_in};

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    wvld_d  = 1'b0;
    eflag_d = 1'b0;
    ecnt_d  = ecnt_q;
    pred    = hist_q[3] ^ hist_q[2];
    if (bus.bit_valid) begin
      // History always takes the received bit, so a corrupted stream re-seeds itself.
      hist_d  = {hist_q[2:0], bus.bit_in};
      shreg_d = shift_w[WIDTH-2:0];
      if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
      if (bcnt_q == BW'(WIDTH-1)) begin
        bcnt_d = '0;
        word_d = shift_w;
        wvld_d = 1'b1;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
      if (fill_q == 3'd4) begin
        case (state_q)
          SEARCH: begin
            // An all-zero history is never a lock candidate (idle-low line).
            if (bus.bit_in == pred && hist_q != 4'd0) begin
              if (match_q == 8'(LOCK_COUNT-1)) begin
                state_d = LOCKED;
                match_d = '0;
              end else begin
                match_d = match_q + 8'd1;
              end
            end else begin
              match_d = '0;
            end
          end
          LOCKED: begin
            if (bus.bit_in != pred) begin
              eflag_d = 1'b1;
`ifdef RANDOM_CHECKER_SAT_EN
              if (ecnt_q != {ERR_W{1'b1}}) ecnt_d = ecnt_q + ERR_W'(1);
`else
              ecnt_d = ecnt_q + ERR_W'(1);
`endif
              if (miss_q == 4'(LOSS_COUNT-1)) begin
                state_d = SEARCH;
                miss_d  = '0;
                match_d = '0;
              end else begin
                miss_d = miss_q + 4'd1;
              end
            end else begin
              miss_d = '0;
            end
          end
          default: state_d = SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      shreg_q <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      wvld_q  <= 1'b0;
      eflag_q <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      wvld_q  <= wvld_d;
      eflag_q <= eflag_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = wvld_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.err_flag   = eflag_q;
  assign bus.err_count  = ecnt_q;
endmodule

// File: tb/tb_random_checker.sv
// Bench for random_checker: two instances (ERR_W=8 and ERR_W=2) share one stimulus and one stream-level model.
module tb_random_checker;
  localparam int WIDTH = 4, LOCK_COUNT = 8, LOSS_COUNT = 3, ERR_W = 8, ERR_W2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bin = 1'b0;
  logic bvld = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  random_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W))  bus_a ();
  random_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W2)) bus_b ();

  assign bus_a.bit_in    = bin;
  assign bus_a.bit_valid = bvld;
  assign bus_b.bit_in    = bin;
  assign bus_b.bit_valid = bvld;

  random_checker #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_W(ERR_W))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  random_checker #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_W(ERR_W2))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  logic ref_seq [15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                         1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  // Reference model: every valid bit since reset kept in a queue; rules applied on the bit history.
  bit               mq[$];
  int               m_match = 0, m_miss = 0, m_err = 0;
  bit               m_lock = 0, m_wvld = 0, m_eflag = 0;
  logic [WIDTH-1:0] m_word = '0;

  task automatic model_step(input bit r, input bit v, input bit b);
    int n;
    bit p, nz;
    m_wvld  = 0;
    m_eflag = 0;
    if (r) begin
      mq.delete();
      m_match = 0; m_miss = 0; m_err = 0; m_lock = 0; m_word = '0;
    end else if (v) begin
      n = mq.size();
      if (n >= 4) begin
        p  = mq[n-4] ^ mq[n-3];
        nz = mq[n-4] | mq[n-3] | mq[n-2] | mq[n-1];
        if (!m_lock) begin
          if (b == p && nz) begin
            m_match++;
            if (m_match == LOCK_COUNT) begin m_lock = 1; m_match = 0; end
          end else m_match = 0;
        end else if (b != p) begin
          m_err++; m_eflag = 1; m_miss++;
          if (m_miss == LOSS_COUNT) begin m_lock = 0; m_miss = 0; m_match = 0; end
        end else m_miss = 0;
      end
      mq.push_back(b);
      if (mq.size() % WIDTH == 0) begin
        for (int i = 0; i < WIDTH; i++) m_word[WIDTH-1-i] = mq[mq.size()-WIDTH+i];
        m_wvld = 1;
      end
    end
  endtask

  function automatic logic [23:0] exp_vec();
    logic [ERR_W-1:0]  ea;
    logic [ERR_W2-1:0] eb;
`ifdef RANDOM_CHECKER_SAT_EN
    ea = (m_err > (1 << ERR_W) - 1)  ? {ERR_W{1'b1}}  : ERR_W'(m_err);
    eb = (m_err > (1 << ERR_W2) - 1) ? {ERR_W2{1'b1}} : ERR_W2'(m_err);
`else
    ea = ERR_W'(m_err % (1 << ERR_W));
    eb = ERR_W2'(m_err % (1 << ERR_W2));
`endif
    return {m_word, m_wvld, m_lock, m_eflag, ea, m_word, m_wvld, m_lock, m_eflag, eb};
  endfunction

  function automatic logic [23:0] obs_vec();
    return {bus_a.word_out, bus_a.word_valid, bus_a.locked, bus_a.err_flag, bus_a.err_count,
            bus_b.word_out, bus_b.word_valid, bus_b.locked, bus_b.err_flag, bus_b.err_count};
  endfunction

  task automatic step(input bit r, input bit v, input bit b);
    rst = r; bvld = v; bin = b;
    @(posedge clk);
    model_step(r, v, b);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0);
    step(1, 1, 1);
    checks++;
    if (obs_vec() !== 24'h0) begin
      errors++; $display("FAIL reset_state got %h exp %h", obs_vec(), 24'h0);
    end
  endtask

  task automatic test_clean();
    int wv = 0;
    step(1, 0, 0);
    for (int i = 0; i < 100; i++) begin
      step(0, 1, ref_seq[i % 15]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL clean_model bit %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (i == 3) begin
        checks++;
        if ({bus_a.word_valid, bus_a.word_out} !== 5'b1_0011) begin
          errors++; $display("FAIL clean_first_word got %b exp %b", {bus_a.word_valid, bus_a.word_out}, 5'b1_0011);
        end
      end
      if (i == 10 || i == 11) begin
        checks++;
        if (bus_a.locked !== (i == 11)) begin
          errors++; $display("FAIL clean_lock_point bit %0d got %b exp %b", i, bus_a.locked, (i == 11));
        end
      end
      wv += int'(bus_a.word_valid);
    end
    checks++;
    if (bus_a.err_count !== 8'd0) begin
      errors++; $display("FAIL clean_errcount got %0d exp 0", bus_a.err_count);
    end
    checks++;
    if (wv !== 25) begin
      errors++; $display("FAIL clean_word_count got %0d exp 25", wv);
    end
  endtask

  task automatic test_flip();
    int ef = 0;
    step(1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      step(0, 1, ref_seq[i % 15] ^ (i == 29));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL flip_model bit %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (i == 29) begin
        checks++;
        if ({bus_a.err_flag, bus_a.err_count} !== {1'b1, 8'd1}) begin
          errors++; $display("FAIL flip_first_err got flag %b cnt %0d exp flag 1 cnt 1", bus_a.err_flag, bus_a.err_count);
        end
      end
      ef += int'(bus_a.err_flag);
    end
    checks++;
    if (bus_a.err_count < 8'd1 || bus_a.err_count > 8'd3 || bus_a.locked !== 1'b1) begin
      errors++; $display("FAIL flip_bound got cnt %0d locked %b exp cnt 1..3 locked 1", bus_a.err_count, bus_a.locked);
    end
    checks++;
    if (ef !== int'(bus_a.err_count)) begin
      errors++; $display("FAIL flip_pulses got %0d pulses exp %0d", ef, bus_a.err_count);
    end
  endtask

  task automatic test_loss();
    step(1, 0, 0);
    // Stop clean data right after a 0,1,0,1 window so forced zeros mispredict three times in a row.
    for (int i = 0; i < 23; i++) begin
      step(0, 1, ref_seq[i % 15]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL loss_pre bit %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
    for (int j = 0; j < 35; j++) begin
      step(0, 1, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL loss_zero bit %0d got %h exp %h", j, obs_vec(), exp_vec());
      end
      if (j == 1 || j == 2) begin
        checks++;
        if (bus_a.locked !== (j == 1) || bus_a.err_flag !== 1'b1 || bus_a.err_count !== 8'(j + 1)) begin
          errors++; $display("FAIL loss_point zero %0d got lk %b ef %b cnt %0d exp lk %b ef 1 cnt %0d",
                             j, bus_a.locked, bus_a.err_flag, bus_a.err_count, (j == 1), j + 1);
        end
      end
    end
    checks++;
    if (bus_a.locked !== 1'b0) begin
      errors++; $display("FAIL loss_no_relock got %b exp 0", bus_a.locked);
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 1, ref_seq[i % 15]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL loss_resume bit %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (i == 10 || i == 11) begin
        checks++;
        if (bus_a.locked !== (i == 11)) begin
          errors++; $display("FAIL relock_point bit %0d got %b exp %b", i, bus_a.locked, (i == 11));
        end
      end
    end
  endtask

  task automatic test_gapped();
    int k = 0, wv = 0;
    logic [WIDTH-1:0] pw;
    logic pl;
    logic [ERR_W-1:0] pe;
    bit v;
    step(1, 0, 0);
    pw = bus_a.word_out; pl = bus_a.locked; pe = bus_a.err_count;
    for (int c = 0; c < 96; c++) begin
      v = (c % 2 == 0);
      step(0, v, v ? ref_seq[k % 15] : 1'($urandom & 1));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL gap_model cyc %0d got %h exp %h", c, obs_vec(), exp_vec());
      end
      if (v) begin
        k++;
        if (k == 11 || k == 12) begin
          checks++;
          if (bus_a.locked !== (k == 12)) begin
            errors++; $display("FAIL gap_lock_point valid %0d got %b exp %b", k, bus_a.locked, (k == 12));
          end
        end
        wv += int'(bus_a.word_valid);
      end else begin
        checks++;
        if ({bus_a.word_out, bus_a.locked, bus_a.err_count, bus_a.word_valid, bus_a.err_flag} !== {pw, pl, pe, 2'b00}) begin
          errors++; $display("FAIL gap_hold cyc %0d got %h exp %h", c,
                             {bus_a.word_out, bus_a.locked, bus_a.err_count, bus_a.word_valid, bus_a.err_flag}, {pw, pl, pe, 2'b00});
        end
      end
      pw = bus_a.word_out; pl = bus_a.locked; pe = bus_a.err_count;
    end
    checks++;
    if (wv !== 12) begin
      errors++; $display("FAIL gap_word_count got %0d exp 12", wv);
    end
  endtask

  task automatic test_overflow();
    bit saw = 0;
    logic [ERR_W2-1:0] pb;
    step(1, 0, 0);
    for (int r = 0; r < 40 && m_err < 6; r++) begin
      for (int i = 0; i < 26; i++) begin
        pb = bus_b.err_count;
        step(0, 1, (i < 16) ? ref_seq[i % 15] : 1'($urandom & 1));
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL ovf_model rnd %0d bit %0d got %h exp %h", r, i, obs_vec(), exp_vec());
        end
`ifdef RANDOM_CHECKER_SAT_EN
        if (bus_b.err_flag && pb == 2'd3 && bus_b.err_count == 2'd3) saw = 1;
`else
        if (bus_b.err_flag && pb == 2'd3 && bus_b.err_count == 2'd0) saw = 1;
`endif
      end
    end
    checks++;
    if (m_err < 6 || !saw) begin
      errors++; $display("FAIL ovf_event got errs %0d boundary_seen %b exp errs>=6 boundary_seen 1", m_err, saw);
    end
  endtask

  task automatic test_reset_mid();
    int wv = 0;
    step(1, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 1, ref_seq[i % 15]);
    step(1, 1, 1);
    checks++;
    if (obs_vec() !== 24'h0) begin
      errors++; $display("FAIL rst_mid_lock got %h exp %h", obs_vec(), 24'h0);
    end
    for (int i = 0; i < 6; i++) step(0, 1, ref_seq[(i + 5) % 15]);
    step(1, 1, 1);
    checks++;
    if (obs_vec() !== 24'h0) begin
      errors++; $display("FAIL rst_after6 got %h exp %h", obs_vec(), 24'h0);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, ref_seq[i]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rst_refill bit %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      wv += int'(bus_a.word_valid);
    end
    checks++;
    if ({bus_a.word_valid, bus_a.word_out} !== 5'b1_0011 || wv !== 1) begin
      errors++; $display("FAIL rst_first_word got vld %b word %b n %0d exp vld 1 word 0011 n 1",
                         bus_a.word_valid, bus_a.word_out, wv);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_flip();
    test_loss();
    test_gapped();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
